// File: rtl/onehot_position_accumulator_if.sv
// onehot_position_accumulator_if: table write, scan control and status bundle
interface onehot_position_accumulator_if #(
  parameter int W = 16,
  parameter int DEPTH = 8,
  parameter int SW = 8
);
  logic wr_en;
  logic [$clog2(DEPTH)-1:0] wr_addr;
  logic [W-1:0] wr_data;
  logic start;
  logic PB;
  logic busy;
  logic done;
  logic [$clog2(DEPTH+1)-1:0] err_count;
  logic [SW-1:0] output_led;
  modport master (output wr_en, wr_addr, wr_data, start, PB, input busy, done, err_count, output_led);
  modport slave (input wr_en, wr_addr, wr_data, start, PB, output busy, done, err_count, output_led);
endinterface

// File: rtl/onehot_position_accumulator.sv
// onehot_position_accumulator: scans a DEPTH-word table summing one-hot bit positions
module onehot_position_accumulator #(
  parameter int W = 16,
  parameter int DEPTH = 8,
  parameter int SW = 8
) (
  input logic clk,
  input logic rst,
  onehot_position_accumulator_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;
  state_t state;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] idx;
  logic [SW-1:0] sum;
  logic [SW-1:0] add;
  logic [W-1:0] word;
  logic oh;
  assign word = mem[idx];
  assign oh = (word != '0) && ((word & (word - W'(1))) == '0);
  // 1-based position of the set bit, truncated to the sum width
  always_comb begin
    add = '0;
    for (int i = 0; i < W; i++) if (word[i]) add = SW'(i + 1);
  end
  // Table writes, scan sequencing, accumulation and display register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      sum <= '0;
      bus.err_count <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.output_led <= '1;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      bus.done <= 1'b0;
      if (state != SCAN && bus.wr_en && int'(bus.wr_addr) < DEPTH) mem[bus.wr_addr] <= bus.wr_data;
      if (state == SCAN) begin
        sum <= oh ? sum + add : sum - SW'(1);
        bus.err_count <= bus.err_count + CW'(!oh);
        if (idx == AW'(DEPTH - 1)) begin
          state <= HOLD;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
        end else begin
          idx <= idx + AW'(1);
        end
      end else begin
        if (state == HOLD) bus.output_led <= bus.PB ? sum : {{(SW-1){1'b0}}, ^sum};
        if (bus.start) begin
          state <= SCAN;
          bus.busy <= 1'b1;
          sum <= '0;
          idx <= '0;
          bus.err_count <= '0;
        end
      end
    end
  end
endmodule
